pixel_array_ctrl: RTL and testbench

Frame sequencer for the four-pixel sensor array. It drives the array through the erase, expose, convert and read phases, and generates the 8-bit ramp-time counter that the pixels latch during conversion. It then reads the four pixels out one at a time onto a valid/ready stream. The block sits between the system control logic and the analog pixel array, and owns both the array control lines and the shared DATA bus.

---
 rtl/pixel_array_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl: frame sequencer for the four-pixel sensor array.
// Walks the array through erase, expose, convert (8-bit ramp on DATA) and
// a one-pixel-at-a-time read-out onto a valid/ready stream.
// Optional feature: define GRAY_CODE_EN to drive the ramp as Gray code and
// decode the pixel codes back to binary on read-out.
module pixel_array_ctrl #(
    parameter int unsigned ERASE_CYCLES  = 5,
    parameter int unsigned EXPOSE_CYCLES = 255,
    parameter int unsigned READ_SETTLE   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       frame_done,
    output logic       pix_reset,
    output logic       pix_erase,
    output logic       pix_expose,
    output logic       pix_convert,
    output logic [3:0] pix_read,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    output logic [7:0] pix_data,
    output logic [1:0] pix_idx,
    output logic       pix_valid,
    input  logic       pix_ready
);

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        HOLD,
        DONE
    } state_t;

    localparam logic [15:0] ERASE_LAST  = 16'(ERASE_CYCLES);
    localparam logic [15:0] EXPOSE_LAST = 16'(EXPOSE_CYCLES);
    localparam logic [15:0] SETTLE_LAST = 16'(READ_SETTLE);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  ramp;
    logic [1:0]  idx;

`ifdef GRAY_CODE_EN
    function automatic logic [7:0] bus_encode(input logic [7:0] c);
        return c ^ (c >> 1);
    endfunction

    function automatic logic [7:0] bus_decode(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`else
    function automatic logic [7:0] bus_encode(input logic [7:0] c);
        return c;
    endfunction

    function automatic logic [7:0] bus_decode(input logic [7:0] g);
        return g;
    endfunction
`endif

    function automatic logic [3:0] one_hot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Frame sequencer: every output is a register updated here. ABORT wins
    // over every other transition and clears everything back to reset values.
    // cnt counts the cycles already spent in ERASE/EXPOSE/READ; READ entered
    // from CONVERT starts at cnt=0 to leave one quiet cycle after DATA_OE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ramp        <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            pix_reset   <= 1'b0;
            pix_erase   <= 1'b0;
            pix_expose  <= 1'b0;
            pix_convert <= 1'b0;
            pix_read    <= '0;
            data_out    <= '0;
            data_oe     <= 1'b0;
            pix_data    <= '0;
            pix_idx     <= '0;
            pix_valid   <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            cnt         <= '0;
            ramp        <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            pix_reset   <= 1'b0;
            pix_erase   <= 1'b0;
            pix_expose  <= 1'b0;
            pix_convert <= 1'b0;
            pix_read    <= '0;
            data_out    <= '0;
            data_oe     <= 1'b0;
            pix_data    <= '0;
            pix_idx     <= '0;
            pix_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ERASE;
                        busy      <= 1'b1;
                        pix_erase <= 1'b1;
                        pix_reset <= 1'b1;
                        cnt       <= 16'd1;
                    end
                end
                ERASE: begin
                    if (cnt == ERASE_LAST) begin
                        state      <= EXPOSE;
                        pix_erase  <= 1'b0;
                        pix_reset  <= 1'b0;
                        pix_expose <= 1'b1;
                        cnt        <= 16'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                EXPOSE: begin
                    if (cnt == EXPOSE_LAST) begin
                        state       <= CONVERT;
                        pix_expose  <= 1'b0;
                        pix_convert <= 1'b1;
                        data_oe     <= 1'b1;
                        ramp        <= 8'd0;
                        data_out    <= bus_encode(8'd0);
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CONVERT: begin
                    if (ramp == 8'hFF) begin
                        state       <= READ;
                        pix_convert <= 1'b0;
                        data_oe     <= 1'b0;
                        data_out    <= '0;
                        cnt         <= '0;
                        idx         <= '0;
                    end else begin
                        ramp     <= ramp + 8'd1;
                        data_out <= bus_encode(ramp + 8'd1);
                    end
                end
                READ: begin
                    if (cnt == 16'd0) begin
                        pix_read <= one_hot(idx);
                        cnt      <= 16'd1;
                    end else if (cnt == SETTLE_LAST) begin
                        state     <= HOLD;
                        pix_read  <= '0;
                        pix_data  <= bus_decode(data_in);
                        pix_idx   <= idx;
                        pix_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (pix_valid && pix_ready) begin
                        pix_valid <= 1'b0;
                        if (idx == 2'd3) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state    <= READ;
                            idx      <= idx + 2'd1;
                            pix_read <= one_hot(idx + 2'd1);
                            cnt      <= 16'd1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    ramp       <= '0;
                    cnt        <= '0;
                    idx        <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl. A timeline model predicts every
// output cycle by cycle from phase lengths and stream handshakes.
// Build with GRAY_CODE_EN defined to exercise the Gray-coded bus.
module tb_pixel_array_ctrl;

    localparam int E     = 5;
    localparam int X     = 255;
    localparam int S     = 2;
    localparam int CONV0 = E + X;
    localparam int READ0 = E + X + 256 + 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       frame_done;
    logic       pix_reset;
    logic       pix_erase;
    logic       pix_expose;
    logic       pix_convert;
    logic [3:0] pix_read;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic [7:0] pix_data;
    logic [1:0] pix_idx;
    logic       pix_valid;
    logic       pix_ready;

    logic [29:0] obs;
    logic [7:0]  pix_val [4];
    logic [7:0]  exp_pd;
    logic [1:0]  exp_pi;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [3:0][7:0] px;
        int rmode;
        int stall_idx;
        int stall_len;
        int busy_start_t;
        int abort_t;
        int exp_done_t;
        int exp_frames;
    } vec_t;

    vec_t tbl [6];

    pixel_array_ctrl #(
        .ERASE_CYCLES (E),
        .EXPOSE_CYCLES(X),
        .READ_SETTLE  (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .frame_done (frame_done),
        .pix_reset  (pix_reset),
        .pix_erase  (pix_erase),
        .pix_expose (pix_expose),
        .pix_convert(pix_convert),
        .pix_read   (pix_read),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .data_in    (data_in),
        .pix_data   (pix_data),
        .pix_idx    (pix_idx),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready)
    );

    always #5 clk = ~clk;

    assign obs = {busy, frame_done, pix_reset, pix_erase, pix_expose, pix_convert,
                  data_oe, pix_valid, pix_read, data_out, pix_data, pix_idx};

    function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef GRAY_CODE_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // Pixel model: the selected pixel drives its latched code onto DATA.
    always_comb begin
        case (pix_read)
            4'b0001: data_in = enc(pix_val[0]);
            4'b0010: data_in = enc(pix_val[1]);
            4'b0100: data_in = enc(pix_val[2]);
            4'b1000: data_in = enc(pix_val[3]);
            default: data_in = 8'hA5;
        endcase
    end

    // Array control lines must never overlap, and DATA must not be driven during a read.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if ((int'(pix_erase) + int'(pix_expose) + int'(pix_convert) + int'(|pix_read)) > 1 ||
                (data_oe && (|pix_read))) begin
                errors++;
                $display("[TB] FAIL exclusion: got erase=%b expose=%b convert=%b read=%b oe=%b, required at most one active",
                         pix_erase, pix_expose, pix_convert, pix_read, data_oe);
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] px, input int rm, input int si, input int sl,
                                input int bst, input int abt, input int edt, input int ef);
        vec_t v;
        v.px           = px;
        v.rmode        = rm;
        v.stall_idx    = si;
        v.stall_len    = sl;
        v.busy_start_t = bst;
        v.abort_t      = abt;
        v.exp_done_t   = edt;
        v.exp_frames   = ef;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [29:0] got, input logic [29:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Runs one frame from the table and compares every cycle against the timeline model.
    task automatic apply_stimulus(input vec_t v, input int id);
        int  k = 0;
        int  rs = READ0;
        int  done_t = -1;
        int  stall_cnt = 0;
        int  n_done = 0;
        int  first_done = -1;
        int  erase_n = 0;
        int  expose_n = 0;
        int  conv_n = 0;
        bit  fin = 1'b0;
        for (int i = 0; i < 4; i++) pix_val[i] = v.px[i];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 3000 && !fin; t++) begin
            bit          ab;
            bit          e_erase, e_expose, e_conv, e_valid, e_done, e_busy;
            logic [3:0]  e_read;
            logic [7:0]  e_dout;
            logic [29:0] exp_vec;
            ab = (v.abort_t >= 0) && (t > v.abort_t);
            e_erase = 0; e_expose = 0; e_conv = 0; e_valid = 0; e_done = 0; e_busy = 0;
            e_read = '0; e_dout = '0;
            if (ab) begin
                exp_pd = '0;
                exp_pi = '0;
            end else begin
                e_erase  = (t < E);
                e_expose = (t >= E) && (t < E + X);
                e_conv   = (t >= CONV0) && (t < CONV0 + 256);
                e_dout   = e_conv ? enc(8'(t - CONV0)) : 8'h00;
                if (k < 4 && t >= rs && t < rs + S) e_read = 4'(4'b0001 << k);
                if (k < 4 && t == rs + S) begin
                    exp_pd = pix_val[k];
                    exp_pi = 2'(k);
                end
                if (k < 4 && t >= rs + S) e_valid = 1'b1;
                e_done = (t == done_t);
                e_busy = (done_t < 0) || (t <= done_t);
            end
            exp_vec = {e_busy, e_done, e_erase, e_erase, e_expose, e_conv, e_conv, e_valid,
                       e_read, e_dout, exp_pd, exp_pi};
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("[TB] FAIL vec%0d cycle %0d: got %h required %h", id, t, obs, exp_vec);
            end
            if (frame_done) begin
                n_done++;
                if (first_done < 0) first_done = t;
            end
            erase_n  += int'(pix_erase);
            expose_n += int'(pix_expose);
            conv_n   += int'(data_oe);
            if (!ab && done_t >= 0 && t == done_t + 1) fin = 1'b1;
            if (ab && t == v.abort_t + 3) fin = 1'b1;
            start = (t == v.busy_start_t);
            abort = (t == v.abort_t);
            if (v.rmode == 1) begin
                if (e_valid && k == v.stall_idx && stall_cnt < v.stall_len) begin
                    pix_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    pix_ready = 1'b1;
                end
            end else if (v.rmode == 2) begin
                pix_ready = 1'($urandom_range(0, 1));
            end else begin
                pix_ready = 1'b1;
            end
            if (!ab && !abort && e_valid && pix_ready) begin
                k++;
                rs = t + 1;
                if (k == 4) done_t = t + 1;
            end
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("[TB] FAIL vec%0d timeout: got no frame end, required end within 3000 cycles", id);
        end
        check_int($sformatf("vec%0d frame_done count", id), n_done, v.exp_frames);
        if (v.exp_done_t >= 0)
            check_int($sformatf("vec%0d frame_done time", id), first_done, v.exp_done_t);
        if (v.abort_t < 0) begin
            check_int($sformatf("vec%0d erase length", id), erase_n, E);
            check_int($sformatf("vec%0d expose length", id), expose_n, X);
            check_int($sformatf("vec%0d convert length", id), conv_n, 256);
        end
    endtask

    initial begin
        bit got_valid;
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b0;
        exp_pd    = '0;
        exp_pi    = '0;
        for (int i = 0; i < 4; i++) pix_val[i] = '0;

        // {pixels 3..0}, ready mode, stall pixel, stall length, start-while-busy t, abort t, done t, frames
        tbl[0] = mk({8'd102, 8'd89, 8'd77, 8'd64}, 0, -1, 0, -1, -1, 529, 1);
        tbl[1] = mk({8'd255, 8'd0, 8'd200, 8'd5},  1,  1, 10, 100, -1, 539, 1);
        tbl[2] = mk($urandom, 2, -1, 0, -1, -1, -1, 1);
        tbl[3] = mk($urandom, 0, -1, 0, -1, CONV0 + 100, -1, 0);
        tbl[4] = mk($urandom, 2, -1, 0, 300, -1, -1, 1);
        tbl[5] = mk(32'h07_80_FE_01, 0, -1, 0, -1, -1, 529, 1);

        repeat (3) @(negedge clk);
        check_output("reset asserted", obs, 30'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("idle after reset", obs, 30'h0);

        for (int i = 0; i < 6; i++) apply_stimulus(tbl[i], i);

        // Reset asserted while a pixel waits in HOLD must clear everything at once.
        pix_ready = 1'b0;
        for (int i = 0; i < 4; i++) pix_val[i] = 8'(8'h30 + i);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_valid = 1'b0;
        for (int t = 0; t < 700 && !got_valid; t++) begin
            if (pix_valid) got_valid = 1'b1;
            else @(negedge clk);
        end
        check_int("valid before reset", int'(got_valid), 1);
        check_int("held pixel data", int'(pix_data), 8'h30);
        reset_n = 1'b0;
        #1;
        check_output("async reset in hold", obs, 30'h0);
        exp_pd = '0;
        exp_pi = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("idle after mid-frame reset", obs, 30'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
